mem_write_checker: RTL and testbench
====================================

Name: mem_write_checker

Overview:
- Synthesizable, parametrised self-check monitor for the processor's data-memory write port (MemWrite/DataAdr/WriteData).
- Watches every write and declares PASS on a configurable signature write (address and data), or FAIL on a write outside an allowed scratch window.
- Adds a watchdog timeout, write/cycle counters and capture of the offending write, so the check runs in FPGA builds as well as in simulation.
- Sits beside the top-level core; its outputs drive the bench or board LEDs.

Parameters:
- ADDR_W, 32, width of the data address bus.
- DATA_W, 32, width of the write data bus.
- PASS_ADDR, 100, address of the success signature write.
- PASS_DATA, 7, data value required at PASS_ADDR.
- SCRATCH_LO, 96, lowest address of the allowed non-signature write window (inclusive).
- SCRATCH_HI, 96, highest address of the allowed window (inclusive); SCRATCH_HI >= SCRATCH_LO.
- TIMEOUT, 1000, cycles in RUN before declaring timeout; 0 disables the watchdog.
- CNT_W, 16, width of the write and cycle counters.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous restart; returns FSM to RUN and zeroes counters/captures.
- MemWrite  input  1  write strobe from the core, sampled at rising clk.
- DataAdr  input  ADDR_W  write address.
- WriteData  input  DATA_W  write data.
- done  output  1  high in PASS, FAIL or TIMEOUT.
- pass  output  1  high in PASS.
- fail  output  1  high in FAIL or TIMEOUT.
- timeout  output  1  high in TIMEOUT only.
- write_count  output  CNT_W  writes observed in RUN, saturating.
- cycle_count  output  CNT_W  cycles spent in RUN, saturating.
- bad_addr  output  ADDR_W  DataAdr of the write that caused FAIL.
- bad_data  output  DATA_W  WriteData of the write that caused FAIL.

Behaviour:
- Reset (reset=0, asynchronous): state=RUN; all outputs 0; counters and captures 0.
- States: RUN, PASS, FAIL, TIMEOUT. PASS, FAIL and TIMEOUT are sticky until reset or clear.
- Transitions in RUN, evaluated on each rising clk with MemWrite=1, in priority order:
  - DataAdr==PASS_ADDR and WriteData==PASS_DATA: go to PASS.
  - Otherwise, DataAdr outside [SCRATCH_LO, SCRATCH_HI]: go to FAIL and capture bad_addr/bad_data.
  - A write to PASS_ADDR with the wrong data is a FAIL, unless PASS_ADDR lies inside the scratch window.
  - A write inside the window: stay in RUN.
- Watchdog:
  - In RUN, cycle_count increments every cycle.
  - When TIMEOUT!=0 and cycle_count reaches TIMEOUT-1 with no transition on that edge, go to TIMEOUT.
  - A PASS/FAIL write on that same edge wins over TIMEOUT.
- write_count increments on every MemWrite=1 cycle in RUN, including the terminating write. Both counters saturate at all-ones and freeze outside RUN.
- Latency: status outputs are registered and assert on the edge that samples the deciding write, visible one edge after MemWrite is presented.
- clear:
  - Takes effect on the next rising edge and overrides any transition on that edge.
  - State=RUN; counters and captures zeroed; done/pass/fail/timeout drop.
- reset asserted mid-run: immediate return to reset values; reset has priority over clear.
- MemWrite=0: address and data are ignored, including X values.
- Comparisons are unsigned, full width.

Test Plan:
- Inputs: reset low 2 cycles, then writes (96,5), (96,9), (100,7) -> pass=1, done=1, fail=0 one edge after (100,7); write_count=3.
- Inputs: writes (96,1), (104,3) -> fail=1, bad_addr=104, bad_data=3; a later (100,7) leaves state FAIL.
- Inputs: write (100,8) with default window -> FAIL, bad_addr=100, bad_data=8.
- Inputs: TIMEOUT=20, no MemWrite -> timeout=1, fail=1 after exactly 20 RUN cycles; cycle_count=20 then frozen. Second run: (100,7) issued on cycle 19 -> PASS, not TIMEOUT.
- Inputs: clear while in FAIL -> next edge: done=0, counters 0, bad_* 0; then (100,7) -> PASS.
- Inputs: SCRATCH_LO=64, SCRATCH_HI=127; reset asserted asynchronously mid-clock during RUN -> outputs zero immediately. Then (64,x) and (127,x) accepted, (128,x) -> FAIL.

Source files
------------

// File: rtl/mem_write_checker.sv
`default_nettype none
// ============================================================================
//  Module      : mem_write_checker
//  Description : Self-check monitor on the data-memory write port. Reports
//                PASS on a signature write, FAIL on an out-of-window write,
//                and TIMEOUT when the watchdog expires.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_write_checker #(
    parameter int          ADDR_W     = 32,
    parameter int          DATA_W     = 32,
    parameter int unsigned PASS_ADDR  = 100,
    parameter int unsigned PASS_DATA  = 7,
    parameter int unsigned SCRATCH_LO = 96,
    parameter int unsigned SCRATCH_HI = 96,
    parameter int unsigned TIMEOUT    = 1000,
    parameter int          CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] DataAdr,
    input  logic [DATA_W-1:0] WriteData,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic              timeout,
    output logic [CNT_W-1:0]  write_count,
    output logic [CNT_W-1:0]  cycle_count,
    output logic [ADDR_W-1:0] bad_addr,
    output logic [DATA_W-1:0] bad_data
);

    localparam logic [ADDR_W-1:0] c_PASS_ADDR  = ADDR_W'(PASS_ADDR);
    localparam logic [DATA_W-1:0] c_PASS_DATA  = DATA_W'(PASS_DATA);
    localparam logic [ADDR_W-1:0] c_SCRATCH_LO = ADDR_W'(SCRATCH_LO);
    localparam logic [ADDR_W-1:0] c_SCRATCH_HI = ADDR_W'(SCRATCH_HI);
    localparam logic [CNT_W-1:0]  c_TO_LAST    = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_PASS    = 2'd1,
        S_FAIL    = 2'd2,
        S_TIMEOUT = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    wcnt_q, wcnt_d;
    logic [CNT_W-1:0]    ccnt_q, ccnt_d;
    logic [ADDR_W-1:0]   bad_addr_q, bad_addr_d;
    logic [DATA_W-1:0]   bad_data_q, bad_data_d;

    logic w_is_sig;
    logic w_in_window;
    logic w_wdog_hit;

    assign w_is_sig    = (DataAdr == c_PASS_ADDR) && (WriteData == c_PASS_DATA);
    assign w_in_window = (DataAdr >= c_SCRATCH_LO) && (DataAdr <= c_SCRATCH_HI);

    // Watchdog fires on the edge where the counter holds TIMEOUT-1, so the
    // state flips together with the count reaching TIMEOUT.
    generate
        if (TIMEOUT != 0) begin : g_wdog
            assign w_wdog_hit = (ccnt_q == c_TO_LAST);
        end else begin : g_no_wdog
            assign w_wdog_hit = 1'b0;
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        wcnt_d     = wcnt_q;
        ccnt_d     = ccnt_q;
        bad_addr_d = bad_addr_q;
        bad_data_d = bad_data_q;

        if (clear) begin
            state_d    = S_RUN;
            wcnt_d     = '0;
            ccnt_d     = '0;
            bad_addr_d = '0;
            bad_data_d = '0;
        end else if (state_q == S_RUN) begin
            if (ccnt_q != '1) begin
                ccnt_d = ccnt_q + 1'b1;
            end
            if (MemWrite) begin
                if (wcnt_q != '1) begin
                    wcnt_d = wcnt_q + 1'b1;
                end
                if (w_is_sig) begin
                    state_d = S_PASS;
                end else if (!w_in_window) begin
                    state_d    = S_FAIL;
                    bad_addr_d = DataAdr;
                    bad_data_d = WriteData;
                end else if (w_wdog_hit) begin
                    state_d = S_TIMEOUT;
                end
            end else if (w_wdog_hit) begin
                state_d = S_TIMEOUT;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_RUN;
            wcnt_q     <= '0;
            ccnt_q     <= '0;
            bad_addr_q <= '0;
            bad_data_q <= '0;
        end else begin
            state_q    <= state_d;
            wcnt_q     <= wcnt_d;
            ccnt_q     <= ccnt_d;
            bad_addr_q <= bad_addr_d;
            bad_data_q <= bad_data_d;
        end
    end

    assign done        = (state_q != S_RUN);
    assign pass        = (state_q == S_PASS);
    assign fail        = (state_q == S_FAIL) || (state_q == S_TIMEOUT);
    assign timeout     = (state_q == S_TIMEOUT);
    assign write_count = wcnt_q;
    assign cycle_count = ccnt_q;
    assign bad_addr    = bad_addr_q;
    assign bad_data    = bad_data_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_write_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_write_checker
//  Description : Scoreboard bench for mem_write_checker; instance A uses the
//                default window, instance B a short watchdog and wide window.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_write_checker;

    logic        clk;
    logic        reset;
    logic        clear;
    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;

    logic        a_done, a_pass, a_fail, a_timeout;
    logic [15:0] a_wcnt, a_ccnt;
    logic [31:0] a_bad_addr, a_bad_data;
    logic        b_done, b_pass, b_fail, b_timeout;
    logic [15:0] b_wcnt, b_ccnt;
    logic [31:0] b_bad_addr, b_bad_data;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string       tag;
        int          sel;
        logic [63:0] exp;
    } exp_t;
    exp_t sb[$];

    mem_write_checker u_dut_a (
        .clk(clk), .reset(reset), .clear(clear), .MemWrite(MemWrite),
        .DataAdr(DataAdr), .WriteData(WriteData),
        .done(a_done), .pass(a_pass), .fail(a_fail), .timeout(a_timeout),
        .write_count(a_wcnt), .cycle_count(a_ccnt),
        .bad_addr(a_bad_addr), .bad_data(a_bad_data)
    );

    mem_write_checker #(
        .SCRATCH_LO(64), .SCRATCH_HI(127), .TIMEOUT(20)
    ) u_dut_b (
        .clk(clk), .reset(reset), .clear(clear), .MemWrite(MemWrite),
        .DataAdr(DataAdr), .WriteData(WriteData),
        .done(b_done), .pass(b_pass), .fail(b_fail), .timeout(b_timeout),
        .write_count(b_wcnt), .cycle_count(b_ccnt),
        .bad_addr(b_bad_addr), .bad_data(b_bad_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Selector codes: 0..7 instance A, 10..17 instance B
    function automatic logic [63:0] obs(input int sel);
        case (sel)
            0:  obs = {63'd0, a_done};
            1:  obs = {63'd0, a_pass};
            2:  obs = {63'd0, a_fail};
            3:  obs = {63'd0, a_timeout};
            4:  obs = {48'd0, a_wcnt};
            5:  obs = {48'd0, a_ccnt};
            6:  obs = {32'd0, a_bad_addr};
            7:  obs = {32'd0, a_bad_data};
            10: obs = {63'd0, b_done};
            11: obs = {63'd0, b_pass};
            12: obs = {63'd0, b_fail};
            13: obs = {63'd0, b_timeout};
            14: obs = {48'd0, b_wcnt};
            15: obs = {48'd0, b_ccnt};
            16: obs = {32'd0, b_bad_addr};
            17: obs = {32'd0, b_bad_data};
            default: obs = 64'hDEAD_BEEF_DEAD_BEEF;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic push(input string tag, input int sel, input logic [63:0] exp);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic push_status(input string tag, input int base,
                               input bit d, input bit p, input bit f, input bit t);
        push({tag, ".done"},    base + 0, {63'd0, d});
        push({tag, ".pass"},    base + 1, {63'd0, p});
        push({tag, ".fail"},    base + 2, {63'd0, f});
        push({tag, ".timeout"}, base + 3, {63'd0, t});
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk(e.tag, obs(e.sel), e.exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        drain();
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        MemWrite  = 1'b1;
        DataAdr   = a;
        WriteData = d;
    endtask

    // Idle cycles float the bus to X: a dropped strobe must ignore it.
    task automatic idle();
        @(negedge clk);
        MemWrite  = 1'b0;
        DataAdr   = 'x;
        WriteData = 'x;
    endtask

    task automatic do_clr(input string tag);
        @(negedge clk);
        MemWrite = 1'b0;
        clear    = 1'b1;
        push_status({tag, ".a"}, 0, 0, 0, 0, 0);
        push({tag, ".a.wcnt"}, 4, 0);
        push({tag, ".a.ccnt"}, 5, 0);
        push({tag, ".a.bad_addr"}, 6, 0);
        push({tag, ".a.bad_data"}, 7, 0);
        push_status({tag, ".b"}, 10, 0, 0, 0, 0);
        push({tag, ".b.ccnt"}, 15, 0);
        tick();
        clear = 1'b0;
    endtask

    initial begin
        reset     = 1'b0;
        clear     = 1'b0;
        MemWrite  = 1'b0;
        DataAdr   = '0;
        WriteData = '0;

        tick();
        push_status("rst", 0, 0, 0, 0, 0);
        push("rst.wcnt", 4, 0);
        push("rst.ccnt", 5, 0);
        push("rst.bad_addr", 6, 0);
        push("rst.bad_data", 7, 0);
        tick();
        @(negedge clk);
        reset = 1'b1;

        // Scratch writes then signature
        drive(96, 5); tick();
        drive(96, 9); push("t1.mid.done", 0, 0); tick();
        drive(100, 7);
        push_status("t1.pass", 0, 1, 1, 0, 0);
        push("t1.wcnt", 4, 3);
        tick();

        // Out-of-window write, then sticky FAIL
        do_clr("clr1");
        drive(96, 1); tick();
        drive(104, 3);
        push_status("t2.fail", 0, 1, 0, 1, 0);
        push("t2.bad_addr", 6, 104);
        push("t2.bad_data", 7, 3);
        push("t2.wcnt", 4, 2);
        tick();
        drive(100, 7);
        push_status("t2.sticky", 0, 1, 0, 1, 0);
        push("t2.sticky.wcnt", 4, 2);
        push("t2.sticky.bad_addr", 6, 104);
        tick();

        // Clear out of FAIL, then pass
        idle(); tick();
        do_clr("clr2");
        drive(100, 7);
        push_status("t5.pass", 0, 1, 1, 0, 0);
        tick();

        // Signature address with wrong data
        do_clr("clr3");
        drive(100, 8);
        push_status("t3.fail", 0, 1, 0, 1, 0);
        push("t3.bad_addr", 6, 100);
        push("t3.bad_data", 7, 8);
        push("t3.wcnt", 4, 1);
        tick();

        // Watchdog expiry on instance B
        do_clr("clr4");
        for (int i = 1; i <= 19; i++) begin
            idle();
            if (i == 19) begin
                push("t4.pre.timeout", 13, 0);
                push("t4.pre.ccnt", 15, 19);
            end
            tick();
        end
        idle();
        push_status("t4.to", 10, 1, 0, 1, 1);
        push("t4.to.ccnt", 15, 20);
        tick();
        for (int i = 0; i < 3; i++) begin
            idle(); tick();
        end
        push("t4.frozen.ccnt", 15, 20);
        push("t4.frozen.timeout", 13, 1);
        idle(); tick();

        // Signature on the watchdog edge beats TIMEOUT
        do_clr("clr5");
        for (int i = 0; i < 19; i++) begin
            idle(); tick();
        end
        drive(100, 7);
        push_status("t4b.pass", 10, 1, 1, 0, 0);
        push("t4b.ccnt", 15, 20);
        push("t4b.wcnt", 14, 1);
        tick();
        idle();
        push_status("t4b.hold", 10, 1, 1, 0, 0);
        push("t4b.hold.ccnt", 15, 20);
        tick();

        // Asynchronous reset mid-cycle, then window edges on B
        do_clr("clr6");
        drive(64, 32'hDEAD); tick();
        drive(128, 1);
        push("t6.prefail", 12, 1);
        push("t6.prefail.bad_addr", 16, 128);
        tick();
        idle();
        #2;
        reset = 1'b0;
        #1;
        push_status("t6.arst", 10, 0, 0, 0, 0);
        push("t6.arst.wcnt", 14, 0);
        push("t6.arst.ccnt", 15, 0);
        push("t6.arst.bad_addr", 16, 0);
        push("t6.arst.bad_data", 17, 0);
        drain();
        @(negedge clk);
        reset = 1'b1;
        drive(64, 1);
        push("t6.lo.done", 10, 0);
        push("t6.lo.wcnt", 14, 1);
        tick();
        drive(127, 2);
        push("t6.hi.done", 10, 0);
        push("t6.hi.wcnt", 14, 2);
        tick();
        idle();
        push("t6.xbus.done", 10, 0);
        push("t6.xbus.wcnt", 14, 2);
        tick();
        drive(128, 7);
        push_status("t6.over", 10, 1, 0, 1, 0);
        push("t6.over.bad_addr", 16, 128);
        push("t6.over.bad_data", 17, 7);
        push("t6.over.wcnt", 14, 3);
        tick();
        idle(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
